// File: rtl/seq_calc_bcd.sv
// Sequential add/sub/pass/multiply calculator with a multi-cycle double-dabble BCD converter.
// Define CALC_MUL_EN to build the shift-add multiplier; otherwise op 11 reports overflow with a zero result.
module seq_calc_bcd #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          X,
    input  logic [W-1:0]          Y,
    input  logic [1:0]            op_sel,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow,
    output logic                  carry_out
);

    localparam int unsigned RW = 2 * W;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(RW + 1);

    localparam logic [CW-1:0] LAST_CONV = CW'(RW - 1);
    localparam logic [RW-1:0] ONE_R     = {{(RW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     mag_q, mag_d;
    logic [BW-1:0]     dig_q, dig_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              cy_q, cy_d;

    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              negative_q, negative_d;
    logic              overflow_q, overflow_d;
    logic              carry_q, carry_d;

    // W-bit adder shared by add, subtract (X + ~Y + 1) and pass.
    logic [W-1:0]      b_opnd;
    logic              cin;
    logic [W:0]        sum;
    logic [W-1:0]      res;
    logic [RW-1:0]     res_ext;
    logic [RW-1:0]     res_mag;
    logic              add_ovf;

    always_comb begin
        b_opnd  = (op_sel == 2'b01) ? ~Y : Y;
        cin     = (op_sel == 2'b01);
        sum     = {1'b0, X} + {1'b0, b_opnd} + {{W{1'b0}}, cin};
        res     = (op_sel == 2'b10) ? X : sum[W-1:0];
        res_ext = {{W{res[W-1]}}, res};
        res_mag = res[W-1] ? (~res_ext + ONE_R) : res_ext;
        add_ovf = (X[W-1] == b_opnd[W-1]) && (sum[W-1] != X[W-1]);
    end

`ifdef CALC_MUL_EN
    localparam logic [CW-1:0] LAST_MUL = CW'(W - 1);
    localparam logic [RW-1:0] HALF     = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    logic [W-1:0]      mcand_q, mcand_d;
    logic [RW-1:0]     prod_q, prod_d;
    logic              msign_q, msign_d;
    logic [W-1:0]      abs_x, abs_y;
    logic [W:0]        partial;
    logic [RW-1:0]     prod_step;

    // Right-shifting product register: upper half accumulates, lower half holds the remaining multiplier bits.
    always_comb begin
        abs_x     = X[W-1] ? (~X + W'(1)) : X;
        abs_y     = Y[W-1] ? (~Y + W'(1)) : Y;
        partial   = {1'b0, prod_q[RW-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
        prod_step = {partial, prod_q[W-1:1]};
    end
`endif

    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    logic [BW-1:0] dig_adj;
    logic [BW-1:0] dig_next;

    always_comb begin
        dig_adj  = dd_adjust(dig_q);
        dig_next = {dig_adj[BW-2:0], mag_q[RW-1]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        dig_d      = dig_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        cy_d       = cy_q;
        valid_d    = 1'b0;
        bcd_d      = bcd_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        carry_d    = carry_q;
`ifdef CALC_MUL_EN
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        msign_d    = msign_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    cnt_d = '0;
                    dig_d = '0;
                    case (op_sel)
                        2'b00, 2'b01: begin
                            mag_d   = res_mag;
                            neg_d   = res[W-1];
                            ovf_d   = add_ovf;
                            cy_d    = sum[W];
                            state_d = CONV;
                        end
                        2'b10: begin
                            mag_d   = res_mag;
                            neg_d   = res[W-1];
                            ovf_d   = 1'b0;
                            cy_d    = 1'b0;
                            state_d = CONV;
                        end
                        default: begin
`ifdef CALC_MUL_EN
                            mcand_d = abs_x;
                            prod_d  = {{W{1'b0}}, abs_y};
                            msign_d = X[W-1] ^ Y[W-1];
                            state_d = MUL;
`else
                            mag_d   = '0;
                            neg_d   = 1'b0;
                            ovf_d   = 1'b1;
                            cy_d    = 1'b0;
                            state_d = CONV;
`endif
                        end
                    endcase
                end
            end
`ifdef CALC_MUL_EN
            MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_MUL) begin
                    // |R| is the product itself; the signed range test is done on the magnitude.
                    cnt_d   = '0;
                    mag_d   = prod_step;
                    neg_d   = msign_q && (prod_step != '0);
                    ovf_d   = neg_d ? (prod_step > HALF) : (prod_step >= HALF);
                    cy_d    = 1'b0;
                    state_d = CONV;
                end
            end
`endif
            CONV: begin
                mag_d = mag_q << 1;
                dig_d = dig_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CONV) begin
                    cnt_d      = '0;
                    state_d    = DONE;
                    valid_d    = 1'b1;
                    bcd_d      = dig_next;
                    negative_d = neg_q;
                    overflow_d = ovf_q;
                    carry_d    = cy_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MUL) || (state_d == CONV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            dig_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cy_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            dig_q      <= dig_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            cy_q       <= cy_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            carry_q    <= carry_d;
        end
    end

`ifdef CALC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            msign_q <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            msign_q <= msign_d;
        end
    end
`endif

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign bcd       = bcd_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_calc_bcd.sv
// Scoreboard bench for seq_calc_bcd: arithmetic reference model, queue of expected results, negedge monitor.
module tb_seq_calc_bcd;

    localparam int W      = 8;
    localparam int DIGITS = 5;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [7:0]  X      = '0;
    logic [7:0]  Y      = '0;
    logic [1:0]  op_sel = '0;
    logic        busy, valid, negative, overflow, carry_out;
    logic [19:0] bcd;

    logic        s_start = 1'b0;
    logic [3:0]  s_X     = '0;
    logic [3:0]  s_Y     = '0;
    logic [1:0]  s_op    = '0;
    logic        s_busy, s_valid, s_neg, s_ovf, s_cy;
    logic [11:0] s_bcd;

    seq_calc_bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y), .op_sel(op_sel),
        .busy(busy), .valid(valid), .bcd(bcd), .negative(negative),
        .overflow(overflow), .carry_out(carry_out)
    );

    seq_calc_bcd #(.W(4), .DIGITS(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .X(s_X), .Y(s_Y), .op_sel(s_op),
        .busy(s_busy), .valid(s_valid), .bcd(s_bcd), .negative(s_neg),
        .overflow(s_ovf), .carry_out(s_cy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint bcd;
        bit     neg;
        bit     ovf;
        bit     cy;
        int     lat;
        int     due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_acc = 0;
    int   last_due = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: signed integer arithmetic, wrap by modulus, decimal digits by division.
    function automatic exp_t model(input int w, input int xr, input int yr, input int op);
        exp_t   e;
        int     m, h, xs, ys;
        longint full, r, mag;
        m = 1 << w;
        h = m / 2;
        xs = (xr >= h) ? xr - m : xr;
        ys = (yr >= h) ? yr - m : yr;
        e.ovf = 0;
        e.cy  = 0;
        e.lat = 2 * w;
        e.due = 0;
        full  = 0;
        r     = 0;
        case (op)
            0: begin full = xs + ys; e.cy = ((xr + yr) >= m); end
            1: begin full = xs - ys; e.cy = (xr >= yr); end
            2: full = xs;
            default: full = 0;
        endcase
        if (op < 3) begin
            r = ((full % m) + m) % m;
            if (r >= h) r = r - m;
            e.ovf = (r != full);
        end else begin
`ifdef CALC_MUL_EN
            r     = xs * ys;
            e.ovf = (r < -h) || (r > h - 1);
            e.lat = 3 * w;
`else
            r     = 0;
            e.ovf = 1;
`endif
        end
        e.neg = (r < 0);
        mag   = (r < 0) ? -r : r;
        e.bcd = 0;
        for (int i = 0; i < 8; i++) begin
            e.bcd = e.bcd | ((mag % 10) << (4 * i));
            mag   = mag / 10;
        end
        return e;
    endfunction

    function automatic bit model_busy();
        return (cyc >= last_acc) && (cyc < last_due);
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: valid=1 at cycle %0d, expected no outstanding result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("latency", cyc, mon_e.due);
                check("bcd", {44'd0, bcd}, mon_e.bcd);
                check("negative", negative, mon_e.neg);
                check("overflow", overflow, mon_e.ovf);
                check("carry_out", carry_out, mon_e.cy);
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op, input int hold);
        exp_t e;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            X = x; Y = y; op_sel = op; start = 1'b1;
            check("busy", busy, model_busy());
            if (!model_busy()) begin
                e = model(W, int'(x), int'(y), int'(op));
                e.due = cyc + 1 + e.lat;
                last_acc = cyc + 1;
                last_due = e.due;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        check("busy", busy, model_busy());
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || model_busy()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    int sx  [4] = '{3, 8, 7, 3};
    int sy  [4] = '{4, 0, 1, 4};
    int sop [4] = '{0, 2, 0, 3};

    initial begin
        exp_t e;
        int   n;
        bit   got;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_bcd", bcd, 0);
        check("rst_negative", negative, 0);
        check("rst_overflow", overflow, 0);
        check("rst_carry", carry_out, 0);
        rst_n = 1'b1;

        issue(8'h03, 8'h04, 2'b00, 1); drain();
        issue(8'h03, 8'h04, 2'b01, 1); drain();
        issue(8'hFF, 8'hFF, 2'b00, 1); drain();
        issue(8'h7F, 8'h01, 2'b00, 1); drain();
        issue(8'h80, 8'h80, 2'b11, 1); drain();
        issue(8'hF4, 8'h0B, 2'b11, 1); drain();
        issue(8'h03, 8'h04, 2'b11, 1); drain();
        issue(8'h80, 8'h01, 2'b10, 1); drain();
        issue(8'h80, 8'h01, 2'b01, 1); drain();

        // start mid-CONV with new operands must be ignored
        issue(8'h03, 8'h04, 2'b00, 1);
        repeat (4) @(negedge clk);
        issue(8'h55, 8'h22, 2'b01, 2);
        drain();

        // start held high: back-to-back results
        issue(8'h12, 8'h34, 2'b00, 40);
        drain();
        issue(8'hC0, 8'h07, 2'b11, 60);
        drain();

        for (int i = 0; i < 60; i++) begin
            issue(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(1, 3));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        drain();

        // asynchronous reset mid-CONV
        issue(8'h90, 8'h90, 2'b00, 1); drain();
        issue(8'h7F, 8'h7F, 2'b00, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_bcd", bcd, 0);
        check("arst_negative", negative, 0);
        check("arst_overflow", overflow, 0);
        check("arst_carry", carry_out, 0);
        sb.delete();
        last_acc = 0;
        last_due = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        issue(8'h09, 8'h0C, 2'b00, 1); drain();

        // narrow instance: W=4, DIGITS=3
        for (int i = 0; i < 4; i++) begin
            e = model(4, sx[i], sy[i], sop[i]);
            @(negedge clk);
            s_X = 4'(sx[i]); s_Y = 4'(sy[i]); s_op = 2'(sop[i]); s_start = 1'b1;
            n = 0;
            got = 0;
            while (!got && n < 40) begin
                @(negedge clk);
                s_start = 1'b0;
                n++;
                if (s_valid) got = 1;
            end
            check("s_latency", n, e.lat + 1);
            check("s_bcd", {52'd0, s_bcd}, e.bcd);
            check("s_negative", s_neg, e.neg);
            check("s_overflow", s_ovf, e.ovf);
            check("s_carry", s_cy, e.cy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
